// File: rtl/instr_encoder_if.sv
// Request/response bundle for the RV32I instruction encoder.
// slave is the encoder side; master is the requester / IMEM-write side.
interface instr_encoder_if #(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned ERR_CNT_W = 16
);
   logic                  in_valid;
   logic                  in_ready;
   logic [3:0]            fmt;
   logic [4:0]            rd;
   logic [4:0]            rs1;
   logic [4:0]            rs2;
   logic [2:0]            funct3;
   logic [6:0]            funct7;
   logic [31:0]           imm;
   logic                  out_valid;
   logic                  out_ready;
   logic [31:0]           out_word;
   logic [ADDR_W-1:0]     out_addr;
   logic [ADDR_W-3:0]     word_count;
   logic                  err_pulse;
   logic [ERR_CNT_W-1:0]  err_count;

   modport slave (
      input  in_valid, fmt, rd, rs1, rs2, funct3, funct7, imm, out_ready,
      output in_ready, out_valid, out_word, out_addr, word_count, err_pulse, err_count
   );

   modport master (
      output in_valid, fmt, rd, rs1, rs2, funct3, funct7, imm, out_ready,
      input  in_ready, out_valid, out_word, out_addr, word_count, err_pulse, err_count
   );
endinterface

// File: rtl/instr_encoder.sv
// Packs decoded RV32I fields into 32-bit instruction words behind a single output register
// stage, stepping the IMEM write address per accepted word and dropping out-of-range requests.
module instr_encoder #(
   parameter int unsigned        ADDR_W    = 32,
   parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
   parameter int unsigned        ERR_CNT_W = 16
) (
   input logic            clk,
   input logic            rst_n,
   input logic            start,
   instr_encoder_if.slave bus
);

   localparam logic [6:0] OpR      = 7'b0110011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;
   localparam logic [6:0] OpLui    = 7'b0110111;

   typedef logic [ADDR_W-3:0] cnt_t;
   typedef enum logic {StEmpty, StFull} state_e;

   state_e                state_q, state_d;
   logic [31:0]           word_q, word_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   cnt_t                  count_q, count_d;
   logic                  err_pulse_q, err_pulse_d;
   logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;

   logic [31:0] enc_word;
   logic        enc_err;
   logic        fits12, fits13, fits21;
   logic        accept, out_hs;

   // Signed range checks: all bits above the field's sign bit must match it.
   assign fits12 = (&bus.imm[31:11]) | ~(|bus.imm[31:11]);
   assign fits13 = (&bus.imm[31:12]) | ~(|bus.imm[31:12]);
   assign fits21 = (&bus.imm[31:20]) | ~(|bus.imm[31:20]);

   assign bus.in_ready = !start && ((state_q == StEmpty) || bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;
   assign out_hs       = (state_q == StFull) && bus.out_ready;

   always_comb begin
      enc_word = '0;
      enc_err  = 1'b0;
      case (bus.fmt)
         4'd0: enc_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, OpR};
         4'd1: begin
            enc_err  = !fits12;
            enc_word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, OpImm};
         end
         4'd2: begin
            enc_err  = !fits12;
            enc_word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, OpLoad};
         end
         4'd3: begin
            enc_err  = !fits12;
            enc_word = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], OpStore};
         end
         4'd4: begin
            enc_err  = !fits13 || bus.imm[0];
            enc_word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                        bus.imm[4:1], bus.imm[11], OpBranch};
         end
         4'd5: begin
            enc_err  = !fits12;
            enc_word = {bus.imm[11:0], bus.rs1, 3'b000, bus.rd, OpJalr};
         end
         4'd6: begin
            enc_err  = !fits21 || bus.imm[0];
            enc_word = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12], bus.rd, OpJal};
         end
         4'd7: begin
            enc_err  = |bus.imm[11:0];
            enc_word = {bus.imm[31:12], bus.rd, OpAuipc};
         end
         4'd8: begin
            enc_err  = |bus.imm[11:0];
            enc_word = {bus.imm[31:12], bus.rd, OpLui};
         end
         default: enc_err = 1'b1;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      word_d      = word_q;
      addr_d      = addr_q;
      count_d     = count_q;
      err_pulse_d = 1'b0;
      err_count_d = err_count_q;
      if (start) begin
         state_d     = StEmpty;
         word_d      = '0;
         addr_d      = BASE_ADDR;
         count_d     = '0;
         err_count_d = '0;
      end else begin
         // Address tracks the presented word, so it steps on the write handshake only.
         if (out_hs) begin
            state_d = StEmpty;
            addr_d  = addr_q + ADDR_W'(4);
            count_d = count_q + cnt_t'(1);
         end
         if (accept) begin
            if (enc_err) begin
               err_pulse_d = 1'b1;
               if (!(&err_count_q)) err_count_d = err_count_q + ERR_CNT_W'(1);
            end else begin
               state_d = StFull;
               word_d  = enc_word;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StEmpty;
         word_q      <= '0;
         addr_q      <= BASE_ADDR;
         count_q     <= '0;
         err_pulse_q <= 1'b0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         word_q      <= word_d;
         addr_q      <= addr_d;
         count_q     <= count_d;
         err_pulse_q <= err_pulse_d;
         err_count_q <= err_count_d;
      end
   end

   assign bus.out_valid  = (state_q == StFull);
   assign bus.out_word   = word_q;
   assign bus.out_addr   = addr_q;
   assign bus.word_count = count_q;
   assign bus.err_pulse  = err_pulse_q;
   assign bus.err_count  = err_count_q;

endmodule
